// File: rtl/lcd_readback.sv
// Reads a run of pixels back from the SDRAM frame buffer through the read FIFO and returns them as a stream.
// Optional read watchdog: define LCD_READBACK_TIMEOUT_EN.
module lcd_readback #(
  parameter int H_DISP    = 1024,
  parameter int V_DISP    = 768,
  parameter int LOAD_WAIT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sys_vaild,
  input  logic [15:0] x_pos,
  input  logic [15:0] y_pos,
  input  logic [23:0] len,
  input  logic        enable,
  output logic        busy,
  output logic        err,
  output logic [23:0] pixel,
  output logic        pixel_valid,
  output logic        pixel_last,
  output logic        sys_load,
  output logic [31:0] sys_addr_min,
  output logic [31:0] sys_addr_max,
  output logic        sys_rd,
  input  logic        sys_rd_ready,
  input  logic [31:0] sys_data
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LOAD = 3'd1;
  localparam logic [2:0] WAIT = 3'd2;
  localparam logic [2:0] READ = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  localparam logic [31:0] FRAME_PIXELS = 32'(H_DISP * V_DISP);

  logic [2:0]  state_reg;
  logic [23:0] n_reg;
  logic [23:0] issued_reg;
  logic [23:0] delivered_reg;
  logic [15:0] wait_cnt_reg;
`ifdef LCD_READBACK_TIMEOUT_EN
  logic [15:0] wdog_reg;
`endif

  logic [31:0] addr_next;
  logic [31:0] remain_next;
  logic [23:0] n_next;
  logic        reject_next;
  logic        rd_is_last;
  logic        unused_bits;

  // The low byte of each FIFO word is padding; the pixel sits in [31:8].
  assign unused_bits = ^sys_data[7:0];

  always_comb begin
    addr_next   = 32'(y_pos) * 32'(H_DISP) + 32'(x_pos);
    remain_next = FRAME_PIXELS - addr_next;
    n_next      = len;
    if ({8'd0, len} > remain_next)
      n_next = remain_next[23:0];
    reject_next = (32'(x_pos) >= 32'(H_DISP)) || (32'(y_pos) >= 32'(V_DISP)) || (len == 24'd0);
  end

  assign sys_rd     = (state_reg == READ) && sys_rd_ready && (issued_reg < n_reg);
  assign rd_is_last = (issued_reg + 24'd1 == n_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      n_reg         <= '0;
      issued_reg    <= '0;
      delivered_reg <= '0;
      wait_cnt_reg  <= '0;
`ifdef LCD_READBACK_TIMEOUT_EN
      wdog_reg      <= '0;
`endif
      busy          <= 1'b0;
      err           <= 1'b0;
      pixel         <= '0;
      pixel_valid   <= 1'b0;
      pixel_last    <= 1'b0;
      sys_load      <= 1'b0;
      sys_addr_min  <= '0;
      sys_addr_max  <= '0;
    end else begin
      err         <= 1'b0;
      sys_load    <= 1'b0;
      pixel_valid <= 1'b0;
      pixel_last  <= 1'b0;

      // FIFO data is captured on the read cycle and presented one cycle later.
      if (sys_rd) begin
        pixel       <= sys_data[31:8];
        pixel_valid <= 1'b1;
        pixel_last  <= rd_is_last;
        issued_reg  <= issued_reg + 24'd1;
      end
      if (pixel_valid)
        delivered_reg <= delivered_reg + 24'd1;

      case (state_reg)
        IDLE: begin
          if (enable && sys_vaild && !busy) begin
            if (reject_next) begin
              err <= 1'b1;
            end else begin
              sys_addr_min  <= addr_next;
              sys_addr_max  <= addr_next + 32'(n_next);
              n_reg         <= n_next;
              issued_reg    <= '0;
              delivered_reg <= '0;
              wait_cnt_reg  <= '0;
              sys_load      <= 1'b1;
              busy          <= 1'b1;
              state_reg     <= LOAD;
            end
          end
        end
        LOAD: state_reg <= WAIT;
        WAIT: begin
          if (wait_cnt_reg == 16'(LOAD_WAIT - 1)) begin
            state_reg <= READ;
`ifdef LCD_READBACK_TIMEOUT_EN
            wdog_reg  <= '0;
`endif
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 16'd1;
          end
        end
        READ: begin
          if (pixel_valid && (delivered_reg + 24'd1 == n_reg)) begin
            busy      <= 1'b0;
            state_reg <= DONE;
          end
`ifdef LCD_READBACK_TIMEOUT_EN
          else if (wdog_reg == 16'hFFFF) begin
            // Abort: no final pixel, so suppress anything captured this cycle.
            err         <= 1'b1;
            busy        <= 1'b0;
            pixel_valid <= 1'b0;
            pixel_last  <= 1'b0;
            state_reg   <= IDLE;
          end else if (pixel_valid) begin
            wdog_reg <= '0;
          end else begin
            wdog_reg <= wdog_reg + 16'd1;
          end
`endif
        end
        DONE: state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
